multi_cycle_ctrl: RTL and testbench

Multi-cycle MIPS control unit. Holds the instruction-phase state register (IF/ID/EXE/MEM/WB) and, from the current state plus the opcode held in IR, drives every datapath enable and mux select. This includes the 2-bit register-destination select for the write-address selector: 00 selects $31, 01 selects rt, 10 selects rd. Sits between IR/ALU flags and the PC, IR, register file, ALU, data memory and datapath muxes.

---
 rtl/cpu_defs.sv | 81 ++++++++
 rtl/multi_cycle_ctrl_if.sv | 35 +++
 rtl/mc_ctrl_decode.sv | 84 ++++++++
 rtl/multi_cycle_ctrl.sv | 81 ++++++++
 tb/tb_multi_cycle_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, FSM states,
// ALU operation codes, datapath select codes and the decoded control bundle.
package cpu_defs;

    typedef enum logic [2:0] {
        ST_IF     = 3'b000,
        ST_ID     = 3'b001,
        ST_EXE_LS = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB_LD  = 3'b100,
        ST_EXE_BR = 3'b101,
        ST_EXE_AL = 3'b110,
        ST_WB_AL  = 3'b111
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SLTIU = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;

    localparam logic [1:0] REGDST_RA = 2'b00;
    localparam logic [1:0] REGDST_RT = 2'b01;
    localparam logic [1:0] REGDST_RD = 2'b10;

    localparam logic [1:0] PCSRC_NEXT   = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_REG    = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    typedef struct packed {
        logic       pc_wre;
        logic       ir_wre;
        logic       ins_mem_rw;
        logic       reg_wre;
        logic [1:0] reg_dst;
        logic       wr_reg_d_src;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       ext_sel;
        logic       db_data_src;
        logic       m_rd;
        logic       m_wr;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
    } ctrl_t;

    // Opcodes that take the EXE_AL / WB_AL path.
    function automatic logic is_alu_op(input logic [5:0] op);
        return (op == OP_ADD)  || (op == OP_SUB) || (op == OP_ADDI) ||
               (op == OP_OR)   || (op == OP_AND) || (op == OP_ORI)  ||
               (op == OP_SLL)  || (op == OP_SLT) || (op == OP_SLTIU);
    endfunction

    function automatic logic is_defined(input logic [5:0] op);
        return is_alu_op(op) || (op == OP_SW) || (op == OP_LW) ||
               (op == OP_BEQ) || (op == OP_BLTZ) || (op == OP_J) ||
               (op == OP_JR) || (op == OP_JAL) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Bundle between the control unit (master) and the datapath (slave): IR opcode and
// ALU flags in, every enable/select plus debug state and retired-instruction count out.
interface multi_cycle_ctrl_if;
    logic [5:0]  opcode;
    logic        zero;
    logic        sign;
    logic        PCWre;
    logic        IRWre;
    logic        InsMemRW;
    logic        RegWre;
    logic [1:0]  RegDst;
    logic        WrRegDSrc;
    logic        ALUSrcA;
    logic        ALUSrcB;
    logic        ExtSel;
    logic        DBDataSrc;
    logic        mRD;
    logic        mWR;
    logic [1:0]  PCSrc;
    logic [2:0]  ALUOp;
    logic [2:0]  state;
    logic [31:0] ins_count;

    modport master (
        input  opcode, zero, sign,
        output PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
               ExtSel, DBDataSrc, mRD, mWR, PCSrc, ALUOp, state, ins_count
    );

    modport slave (
        output opcode, zero, sign,
        input  PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
               ExtSel, DBDataSrc, mRD, mWR, PCSrc, ALUOp, state, ins_count
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode: (state, opcode, zero, sign) -> datapath control bundle.
// Opcode-dependent selects are driven in every state; enables are qualified by state.
module mc_ctrl_decode
    import cpu_defs::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       sign,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl              = '0;
        ctrl.ins_mem_rw   = 1'b1;
        ctrl.ext_sel      = 1'b1;
        ctrl.wr_reg_d_src = 1'b1;
        ctrl.reg_dst      = REGDST_RA;
        ctrl.alu_op       = ALU_ADD;
        ctrl.pc_src       = PCSRC_NEXT;

        case (opcode)
            OP_ADD:   ctrl.reg_dst = REGDST_RD;
            OP_SUB:   begin ctrl.reg_dst = REGDST_RD; ctrl.alu_op = ALU_SUB; end
            OP_ADDI:  begin ctrl.reg_dst = REGDST_RT; ctrl.alu_src_b = 1'b1; end
            OP_OR:    begin ctrl.reg_dst = REGDST_RD; ctrl.alu_op = ALU_OR; end
            OP_AND:   begin ctrl.reg_dst = REGDST_RD; ctrl.alu_op = ALU_AND; end
            OP_ORI:   begin
                ctrl.reg_dst   = REGDST_RT;
                ctrl.alu_op    = ALU_OR;
                ctrl.alu_src_b = 1'b1;
                ctrl.ext_sel   = 1'b0;
            end
            OP_SLL:   begin ctrl.reg_dst = REGDST_RD; ctrl.alu_op = ALU_SLL; ctrl.alu_src_a = 1'b1; end
            OP_SLT:   begin ctrl.reg_dst = REGDST_RD; ctrl.alu_op = ALU_SLT; end
            OP_SLTIU: begin
                ctrl.reg_dst   = REGDST_RT;
                ctrl.alu_op    = ALU_SLTU;
                ctrl.alu_src_b = 1'b1;
                ctrl.ext_sel   = 1'b0;
            end
            OP_SW:    ctrl.alu_src_b = 1'b1;
            OP_LW:    begin ctrl.reg_dst = REGDST_RT; ctrl.alu_src_b = 1'b1; end
            OP_BEQ:   ctrl.alu_op = ALU_SUB;
            OP_BLTZ:  ctrl.alu_op = ALU_SUB;
            OP_JR:    ctrl.pc_src = PCSRC_REG;
            OP_J:     ctrl.pc_src = PCSRC_JUMP;
            OP_JAL:   begin ctrl.pc_src = PCSRC_JUMP; ctrl.wr_reg_d_src = 1'b0; end
            default:  ;
        endcase

        case (state)
            ST_IF:     ctrl.ir_wre = 1'b1;
            // Jumps and undefined opcodes retire here; halt deliberately never loads PC.
            ST_ID: begin
                ctrl.pc_wre  = (opcode == OP_J) || (opcode == OP_JR) ||
                               (opcode == OP_JAL) || !is_defined(opcode);
                ctrl.reg_wre = (opcode == OP_JAL);
            end
            ST_EXE_BR: begin
                ctrl.pc_wre = 1'b1;
                if (((opcode == OP_BEQ) && zero) || ((opcode == OP_BLTZ) && sign))
                    ctrl.pc_src = PCSRC_BRANCH;
            end
            ST_MEM: begin
                ctrl.m_rd        = (opcode == OP_LW);
                ctrl.m_wr        = (opcode == OP_SW);
                ctrl.db_data_src = (opcode == OP_LW);
                ctrl.pc_wre      = (opcode == OP_SW);
            end
            ST_WB_LD: begin
                ctrl.pc_wre      = 1'b1;
                ctrl.reg_wre     = 1'b1;
                ctrl.db_data_src = 1'b1;
            end
            ST_WB_AL: begin
                ctrl.pc_wre  = 1'b1;
                ctrl.reg_wre = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control unit: instruction-phase state register, next-state logic
// and retired-instruction counter; control decode lives in mc_ctrl_decode.
module multi_cycle_ctrl
    import cpu_defs::*;
(
    input  logic                CLK,
    input  logic                Reset,
    multi_cycle_ctrl_if.master  bus
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] count_q;
    ctrl_t       ctrl;
    logic        pc_wre;

    mc_ctrl_decode u_decode (
        .state  (state_q),
        .opcode (bus.opcode),
        .zero   (bus.zero),
        .sign   (bus.sign),
        .ctrl   (ctrl)
    );

    always_comb begin
        state_d = ST_IF;
        case (state_q)
            ST_IF:     state_d = ST_ID;
            ST_ID: begin
                if ((bus.opcode == OP_BEQ) || (bus.opcode == OP_BLTZ))
                    state_d = ST_EXE_BR;
                else if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW))
                    state_d = ST_EXE_LS;
                else if (is_alu_op(bus.opcode))
                    state_d = ST_EXE_AL;
                else
                    state_d = ST_IF;
            end
            ST_EXE_AL: state_d = ST_WB_AL;
            ST_WB_AL:  state_d = ST_IF;
            ST_EXE_BR: state_d = ST_IF;
            ST_EXE_LS: state_d = ST_MEM;
            ST_MEM:    state_d = (bus.opcode == OP_LW) ? ST_WB_LD : ST_IF;
            ST_WB_LD:  state_d = ST_IF;
            default:   state_d = ST_IF;
        endcase
    end

    // Reset is asynchronous, so the write strobes are gated by it directly to
    // guarantee nothing half-completes while it is held.
    assign pc_wre = ctrl.pc_wre & Reset;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IF;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (pc_wre)
                count_q <= count_q + 32'd1;
        end
    end

    assign bus.PCWre     = pc_wre;
    assign bus.IRWre     = ctrl.ir_wre & Reset;
    assign bus.InsMemRW  = ctrl.ins_mem_rw;
    assign bus.RegWre    = ctrl.reg_wre & Reset;
    assign bus.RegDst    = ctrl.reg_dst;
    assign bus.WrRegDSrc = ctrl.wr_reg_d_src;
    assign bus.ALUSrcA   = ctrl.alu_src_a;
    assign bus.ALUSrcB   = ctrl.alu_src_b;
    assign bus.ExtSel    = ctrl.ext_sel;
    assign bus.DBDataSrc = ctrl.db_data_src;
    assign bus.mRD       = ctrl.m_rd & Reset;
    assign bus.mWR       = ctrl.m_wr & Reset;
    assign bus.PCSrc     = ctrl.pc_src;
    assign bus.ALUOp     = ctrl.alu_op;
    assign bus.state     = state_q;
    assign bus.ins_count = count_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: a reference model pushes the expected
// control word and count for every cycle; the DUT is compared on the falling edge.
module tb_multi_cycle_ctrl;

    localparam int W = 53;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    multi_cycle_ctrl_if bus ();

    multi_cycle_ctrl dut (
        .CLK   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [2:0]   m_state;
    logic [31:0]  m_count;

    logic [5:0] op_tab [0:17] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                                  6'b010010, 6'b011000, 6'b100110, 6'b100111, 6'b110000,
                                  6'b110001, 6'b110100, 6'b110110, 6'b111000, 6'b111001,
                                  6'b111010, 6'b101010, 6'b001111};
    int         lat_tab [0:17] = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, 3, 3, 2, 2, 2, 2, 2};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {state, PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
    //  ExtSel, DBDataSrc, mRD, mWR, PCSrc, ALUOp}
    function automatic logic [20:0] model_ctrl(input logic [2:0] st, input logic [5:0] op,
                                               input logic z, input logic s, input logic in_rst);
        logic pcw, irw, rw, wsrc, sa, sb, ext, dbs, rd, wr, known;
        logic [1:0] rdst, pcs;
        logic [2:0] aop;
        rdst = 2'b00; aop = 3'b000; sa = 1'b0; sb = 1'b0; ext = 1'b1; wsrc = 1'b1;
        pcs = 2'b00; known = 1'b1;
        case (op)
            6'b000000: rdst = 2'b10;
            6'b000001: begin rdst = 2'b10; aop = 3'b001; end
            6'b000010: begin rdst = 2'b01; sb = 1'b1; end
            6'b010000: begin rdst = 2'b10; aop = 3'b011; end
            6'b010001: begin rdst = 2'b10; aop = 3'b100; end
            6'b010010: begin rdst = 2'b01; aop = 3'b011; sb = 1'b1; ext = 1'b0; end
            6'b011000: begin rdst = 2'b10; aop = 3'b010; sa = 1'b1; end
            6'b100110: begin rdst = 2'b10; aop = 3'b110; end
            6'b100111: begin rdst = 2'b01; aop = 3'b101; sb = 1'b1; ext = 1'b0; end
            6'b110000: sb = 1'b1;
            6'b110001: begin rdst = 2'b01; sb = 1'b1; end
            6'b110100, 6'b110110: aop = 3'b001;
            6'b111000: pcs = 2'b11;
            6'b111001: pcs = 2'b10;
            6'b111010: begin pcs = 2'b11; wsrc = 1'b0; end
            6'b111111: ;
            default:   known = 1'b0;
        endcase
        irw = (st == 3'b000);
        pcw = ((st == 3'b001) && ((op == 6'b111000) || (op == 6'b111001) || (op == 6'b111010) || !known))
              || (st == 3'b101) || ((st == 3'b011) && (op == 6'b110000)) || (st == 3'b111) || (st == 3'b100);
        rw  = (st == 3'b111) || (st == 3'b100) || ((st == 3'b001) && (op == 6'b111010));
        rd  = (st == 3'b011) && (op == 6'b110001);
        wr  = (st == 3'b011) && (op == 6'b110000);
        dbs = ((st == 3'b011) || (st == 3'b100)) && (op == 6'b110001);
        if ((st == 3'b101) && (((op == 6'b110100) && z) || ((op == 6'b110110) && s)))
            pcs = 2'b01;
        if (in_rst) begin
            pcw = 1'b0; irw = 1'b0; rw = 1'b0; rd = 1'b0; wr = 1'b0;
        end
        return {st, pcw, irw, 1'b1, rw, rdst, wsrc, sa, sb, ext, dbs, rd, wr, pcs, aop};
    endfunction

    function automatic logic [2:0] model_next(input logic [2:0] st, input logic [5:0] op);
        case (st)
            3'b000: return 3'b001;
            3'b001: begin
                if (op == 6'b110100 || op == 6'b110110) return 3'b101;
                if (op == 6'b110001 || op == 6'b110000) return 3'b010;
                if (op inside {6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                               6'b010010, 6'b011000, 6'b100110, 6'b100111}) return 3'b110;
                return 3'b000;
            end
            3'b110: return 3'b111;
            3'b010: return 3'b011;
            3'b011: return (op == 6'b110001) ? 3'b100 : 3'b000;
            default: return 3'b000;
        endcase
    endfunction

    // One clock cycle: flags are random except in EXE_BR, where the instruction's flags apply.
    task automatic step(input logic z, input logic s);
        logic [20:0]  e;
        logic [W-1:0] item;
        if (m_state == 3'b101) begin
            bus.zero = z;
            bus.sign = s;
        end else begin
            bus.zero = 1'($urandom_range(0, 1));
            bus.sign = 1'($urandom_range(0, 1));
        end
        e = model_ctrl(m_state, bus.opcode, bus.zero, bus.sign, !rst_n);
        exp_q.push_back({m_count, e});
        @(negedge clk);
        item = exp_q.pop_front();
        check_val($sformatf("ctrl_st%b_op%b", item[20:18], bus.opcode),
                  {43'd0, bus.state, bus.PCWre, bus.IRWre, bus.InsMemRW, bus.RegWre, bus.RegDst,
                   bus.WrRegDSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ExtSel, bus.DBDataSrc,
                   bus.mRD, bus.mWR, bus.PCSrc, bus.ALUOp},
                  {43'd0, item[20:0]});
        check_val("ins_count", {32'd0, bus.ins_count}, {32'd0, item[W-1:21]});
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (e[17]) m_count++;
            m_state = model_next(m_state, bus.opcode);
        end else begin
            m_state = 3'b000;
            m_count = 32'd0;
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic z, input logic s, input int lat);
        int cycles;
        bus.opcode = op;
        cycles = 0;
        do begin
            step(z, s);
            cycles++;
        end while (bus.state !== 3'b000 && cycles < 12);
        check_val($sformatf("latency_%b", op), 64'(cycles), 64'(lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] halt_cnt;
        int          idx;
        bus.opcode = 6'b000000;
        bus.zero   = 1'b0;
        bus.sign   = 1'b0;
        m_state    = 3'b000;
        m_count    = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        step(1'b0, 1'b0);
        rst_n = 1'b1;

        run_instr(6'b000010, 1'b0, 1'b0, 4);
        run_instr(6'b110001, 1'b0, 1'b0, 5);
        run_instr(6'b110000, 1'b0, 1'b0, 4);
        run_instr(6'b111010, 1'b0, 1'b0, 2);
        run_instr(6'b110100, 1'b1, 1'b0, 3);
        run_instr(6'b110100, 1'b0, 1'b1, 3);
        run_instr(6'b110110, 1'b0, 1'b1, 3);
        run_instr(6'b110110, 1'b1, 1'b0, 3);
        run_instr(6'b111000, 1'b0, 1'b0, 2);
        run_instr(6'b111001, 1'b0, 1'b0, 2);
        run_instr(6'b101010, 1'b0, 1'b0, 2);
        run_instr(6'b011000, 1'b0, 1'b0, 4);
        run_instr(6'b100111, 1'b0, 1'b0, 4);

        halt_cnt = m_count;
        repeat (5) run_instr(6'b111111, 1'b0, 1'b0, 2);
        check_val("halt_count", {32'd0, bus.ins_count}, {32'd0, halt_cnt});

        // Abort an add in WB_AL with an asynchronous reset.
        bus.opcode = 6'b000000;
        repeat (3) step(1'b0, 1'b0);
        rst_n   = 1'b0;
        m_state = 3'b000;
        m_count = 32'd0;
        #1;
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        run_instr(6'b000000, 1'b0, 1'b0, 4);

        for (int i = 0; i < 20; i++) begin
            idx = $urandom_range(0, 17);
            run_instr(op_tab[idx], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lat_tab[idx]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
